// File: rtl/simmem_pkg.sv
// Shared widths and the slot record for the simulated-memory delay path.
package simmem_pkg;

   localparam int IDWidth      = 4;
   localparam int NumSlots     = 8;
   localparam int DelayWidth   = 8;
   localparam int SlotIdxWidth = $clog2(NumSlots);
   localparam int NumIds       = 2 ** IDWidth;

   typedef struct packed {
      logic                  valid;
      logic [IDWidth-1:0]    id;
      logic [DelayWidth-1:0] counter;
   } delay_slot_t;

endpackage

// File: rtl/simmem_age_matrix.sv
// Pairwise allocation order of the delay slots: older[i][j] set means slot i
// was allocated before slot j.
module simmem_age_matrix
   import simmem_pkg::*;
(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   alloc,
   input  logic [SlotIdxWidth-1:0]                alloc_idx,
   input  logic [NumSlots-1:0]                    alloc_mask,
   input  logic                                   clear,
   input  logic [SlotIdxWidth-1:0]                clear_idx,
   output logic [NumSlots-1:0][NumSlots-1:0]      older
);

   // A retiring slot never coincides with the allocated one, so both updates
   // can apply in the same cycle without conflicting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         older <= '0;
      end else begin
         if (clear) begin
            for (int j = 0; j < NumSlots; j++) begin
               older[j][clear_idx] <= 1'b0;
            end
            older[clear_idx] <= '0;
         end
         if (alloc) begin
            for (int j = 0; j < NumSlots; j++) begin
               older[j][alloc_idx] <= alloc_mask[j];
            end
            older[alloc_idx] <= '0;
         end
      end
   end

endmodule

// File: rtl/simmem_delay_releaser.sv
// Per-transaction delay countdown that releases the oldest pending response
// of each ID once its delay has elapsed.
module simmem_delay_releaser
   import simmem_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [IDWidth-1:0]    req_id_i,
   input  logic [DelayWidth-1:0] req_delay_i,
   output logic [NumIds-1:0]     release_en_o,
   input  logic                  rsp_valid_i,
   input  logic                  rsp_ready_i,
   input  logic [IDWidth-1:0]    rsp_id_i
);

   delay_slot_t                       slots [NumSlots];
   logic [NumSlots-1:0]               valid;
   logic [NumSlots-1:0]               head;
   logic [NumSlots-1:0]               ret_sel;
   logic [NumSlots-1:0]               ret_vec;
   logic [NumSlots-1:0][NumSlots-1:0] older;
   logic [SlotIdxWidth-1:0]           free_idx;
   logic [SlotIdxWidth-1:0]           ret_idx;
   logic                              alloc;
   logic                              rsp_fire;
   logic                              ret_hit;
   logic                              ret_expired;
   logic                              retire;

   always_comb begin
      for (int i = 0; i < NumSlots; i++) begin
         valid[i] = slots[i].valid;
      end
   end

   // Lowest-index free slot, taken from registered valid bits only.
   always_comb begin
      free_idx = '0;
      for (int i = NumSlots - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_idx = SlotIdxWidth'(i);
         end
      end
   end

   assign req_ready_o = |(~valid);
   assign alloc       = req_valid_i && req_ready_o;
   assign rsp_fire    = rsp_valid_i && rsp_ready_i;

   // A slot heads its ID when no other live slot of that ID is older.
   always_comb begin
      for (int i = 0; i < NumSlots; i++) begin
         head[i] = valid[i];
         for (int j = 0; j < NumSlots; j++) begin
            if (j != i && valid[j] && slots[j].id == slots[i].id && older[j][i]) begin
               head[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      release_en_o = '0;
      for (int i = 0; i < NumSlots; i++) begin
         if (head[i] && slots[i].counter == '0) begin
            release_en_o[slots[i].id] = 1'b1;
         end
      end
   end

   always_comb begin
      ret_hit     = 1'b0;
      ret_expired = 1'b0;
      ret_idx     = '0;
      for (int i = 0; i < NumSlots; i++) begin
         ret_sel[i] = head[i] && slots[i].id == rsp_id_i;
         if (ret_sel[i]) begin
            ret_hit     = 1'b1;
            ret_expired = slots[i].counter == '0;
            ret_idx     = SlotIdxWidth'(i);
         end
      end
   end

   assign retire  = rsp_fire && ret_hit && ret_expired;
   assign ret_vec = retire ? ret_sel : '0;

   // Counters saturate at zero; the retiring slot is already at zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumSlots; i++) begin
            slots[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumSlots; i++) begin
            if (slots[i].valid && slots[i].counter != '0) begin
               slots[i].counter <= slots[i].counter - DelayWidth'(1);
            end
            if (ret_vec[i]) begin
               slots[i].valid <= 1'b0;
            end
            if (alloc && free_idx == SlotIdxWidth'(i)) begin
               slots[i] <= '{valid: 1'b1, id: req_id_i, counter: req_delay_i};
            end
         end
      end
   end

   simmem_age_matrix u_age (
      .clk        (clk_i),
      .rst        (rst_i),
      .alloc      (alloc),
      .alloc_idx  (free_idx),
      .alloc_mask (valid & ~ret_vec),
      .clear      (retire),
      .clear_idx  (ret_idx),
      .older      (older)
   );

   retire_legal: assert property (@(posedge clk_i) disable iff (rst_i)
      rsp_fire |-> (ret_hit && ret_expired));

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// Randomized scoreboard bench for simmem_delay_releaser against a per-ID
// arrival-order model using absolute expiry times.
module tb_simmem_delay_releaser;
   import simmem_pkg::*;

   logic                  clk_i = 1'b0;
   logic                  rst_i = 1'b1;
   logic                  req_valid_i = 1'b0;
   logic                  req_ready_o;
   logic [IDWidth-1:0]    req_id_i = '0;
   logic [DelayWidth-1:0] req_delay_i = '0;
   logic [NumIds-1:0]     release_en_o;
   logic                  rsp_valid_i = 1'b0;
   logic                  rsp_ready_i = 1'b0;
   logic [IDWidth-1:0]    rsp_id_i = '0;

   typedef struct {
      int     id;
      longint ready_at;
   } pend_t;

   typedef struct {
      logic [NumIds-1:0] rel;
      logic              rdy;
   } exp_t;

   pend_t  mq[$];
   exp_t   exp_q[$];
   int     n_vec  = 0;
   int     n_fail = 0;
   longint edges  = 0;

   simmem_delay_releaser dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_id_i     (req_id_i),
      .req_delay_i  (req_delay_i),
      .release_en_o (release_en_o),
      .rsp_valid_i  (rsp_valid_i),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_id_i     (rsp_id_i)
   );

   always #5 clk_i = ~clk_i;

   // The oldest pending entry per ID releases once its expiry time is reached.
   function automatic logic [NumIds-1:0] model_release(longint now);
      logic [NumIds-1:0] r;
      logic [NumIds-1:0] seen;
      r    = '0;
      seen = '0;
      foreach (mq[i]) begin
         if (!seen[mq[i].id]) begin
            seen[mq[i].id] = 1'b1;
            if (now >= mq[i].ready_at) r[mq[i].id] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic int head_of(int id);
      foreach (mq[i]) begin
         if (mq[i].id == id) return i;
      end
      return -1;
   endfunction

   task automatic applyStimulus(input bit rv, input int rid, input int rd,
                                input bit sv, input bit sr, input int sid,
                                input bit do_rst);
      int   h;
      bit   fire;
      bit   accept;
      exp_t e;
      logic [31:0] rid_v;
      logic [31:0] rd_v;
      logic [31:0] sid_v;
      @(negedge clk_i);
      rid_v = rid;
      rd_v  = rd;
      sid_v = sid;
      h     = head_of(sid);
      fire  = sv && sr;
      if (fire && !(h >= 0 && edges >= mq[h].ready_at)) fire = 1'b0;
      rst_i       = do_rst;
      req_valid_i = rv;
      req_id_i    = rid_v[IDWidth-1:0];
      req_delay_i = rd_v[DelayWidth-1:0];
      rsp_valid_i = sv;
      rsp_ready_i = fire ? 1'b1 : (sv ? 1'b0 : sr);
      rsp_id_i    = sid_v[IDWidth-1:0];
      if (fire) rsp_valid_i = 1'b1;
      edges++;
      if (do_rst) begin
         mq.delete();
      end else begin
         accept = rv && (mq.size() < NumSlots);
         if (fire) mq.delete(h);
         if (accept) mq.push_back('{id: rid, ready_at: edges + longint'(rd)});
      end
      e.rel = model_release(edges);
      e.rdy = mq.size() < NumSlots;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic pick_expired(output bit ok, output int k);
      logic [NumIds-1:0] rel;
      int cnt;
      rel = model_release(edges);
      ok  = rel != '0;
      k   = 0;
      cnt = 0;
      for (int i = 0; i < NumIds; i++) begin
         if (rel[i]) begin
            cnt++;
            if ($urandom_range(cnt - 1, 0) == 0) k = i;
         end
      end
   endtask

   task automatic drain();
      bit ok;
      int k;
      for (int n = 0; n < 3000 && mq.size() != 0; n++) begin
         pick_expired(ok, k);
         if (ok) applyStimulus(0, 0, 0, 1, 1, k, 0);
         else    applyStimulus(0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   // Compare whatever the DUT shows just after each edge with the oldest expectation.
   initial begin : checkOutput
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (release_en_o !== e.rel) begin
               n_fail++;
               $display("[TB] FAIL release_en got=%h exp=%h t=%0t", release_en_o, e.rel, $time);
            end
            n_vec++;
            if (req_ready_o !== e.rdy) begin
               n_fail++;
               $display("[TB] FAIL req_ready got=%b exp=%b t=%0t", req_ready_o, e.rdy, $time);
            end
         end
      end
   end

   initial begin
      bit ok;
      int k;
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 1);
      idle(20);

      applyStimulus(1, 3, 5, 0, 0, 0, 0);
      idle(7);
      applyStimulus(0, 0, 0, 1, 1, 3, 0);
      idle(2);

      applyStimulus(1, 2, 10, 0, 0, 0, 0);
      applyStimulus(1, 2, 0, 0, 0, 0, 0);
      idle(10);
      applyStimulus(0, 0, 0, 1, 1, 2, 0);
      idle(1);
      applyStimulus(0, 0, 0, 1, 1, 2, 0);
      idle(2);

      applyStimulus(1, 1, 4, 0, 0, 0, 0);
      applyStimulus(1, 7, 1, 0, 0, 0, 0);
      idle(5);
      applyStimulus(0, 0, 0, 1, 1, 7, 0);
      applyStimulus(0, 0, 0, 1, 1, 1, 0);

      for (int i = 0; i < NumSlots; i++) applyStimulus(1, $urandom_range(15, 0), 200, 0, 0, 0, 0);
      repeat (200) applyStimulus(1, 5, 3, 1, 0, $urandom_range(15, 0), 0);
      pick_expired(ok, k);
      applyStimulus(1, 5, 3, 1, 1, k, 0);
      applyStimulus(1, 5, 3, 0, 0, 0, 0);
      drain();

      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      idle(300);
      applyStimulus(0, 0, 0, 1, 1, 0, 0);
      idle(2);

      for (int n = 0; n < 3000; n++) begin
         int rd;
         rd = ($urandom_range(19, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(12, 0);
         if ($urandom_range(499, 0) == 0) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
         end else begin
            pick_expired(ok, k);
            if (ok && $urandom_range(1, 0) == 1)
               applyStimulus($urandom_range(1, 0), $urandom_range(15, 0), rd, 1, 1, k, 0);
            else
               applyStimulus($urandom_range(1, 0), $urandom_range(15, 0), rd,
                             $urandom_range(1, 0), $urandom_range(1, 0) & 1'b0,
                             $urandom_range(15, 0), 0);
         end
      end
      drain();
      idle(2);

      @(posedge clk_i);
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
